factorial: RTL and testbench
============================

// Module: factorial
// PURPOSE
//   Sequential factorial engine: on a go request it latches a 4-bit operand n
//   and computes n! by iterative multiply, one multiply per clock.
//   Produces a 32-bit result (modulo 2^32), a done pulse, an overflow error flag
//   and a visible state code.
//   Standalone datapath+FSM accelerator used as a course-project peripheral.
// PARAMETERS
//   none (widths fixed: operand 4 bits, result 32 bits)
// PORTS
//   clk     in   1   system clock, all logic on rising edge
//   rst     in   1   synchronous, active-high reset
//   go      in   1   start request, level-sensitive, sampled only in IDLE
//   in      in   4   operand n (0..15), latched when a start is accepted
//   Done    out  1   high for exactly one cycle when result is valid
//   Error   out  1   overflow flag: n > 12 (n! exceeds 32 bits)
//   CS      out  2   current FSM state code
//   result  out  32  last completed n! mod 2^32, held between runs
// BEHAVIOUR
//   Interface: one clock (clk); reset is synchronous and active-high (rst).
//   Reset (rst=1 at posedge):
//   - state=IDLE, Done=0, Error=0, result=0, internal cnt=0, acc=0.
//   - rst mid-run aborts the computation immediately; no Done pulse is produced.
//   FSM, CS encoding: IDLE=2'b00, LOAD=2'b01, MULT=2'b10, DONE=2'b11.
//   IDLE:
//   - if go=1: cnt<=in, acc<=1, Error<=(in>12), go to LOAD.
//   - else stay.
//   LOAD: go to MULT if cnt>1, else go to DONE (covers 0!=1, 1!=1).
//   MULT:
//   - each cycle acc<=acc*cnt (low 32 bits kept), cnt<=cnt-1.
//   - when the updated cnt would be <=1, go to DONE.
//   DONE:
//   - result<=acc, Done=1 for this single cycle, go to IDLE.
//   Error:
//   - updated only when a start is accepted; holds its value until the next start.
//   Outputs and handshake:
//   - result changes only on entry to DONE. It is stable while a new run is
//     in progress and after a reset-free return to IDLE.
//   - go held continuously high: the engine restarts from IDLE on the next
//     cycle, re-sampling in at that time (back-to-back runs allowed).
//   - in changes outside IDLE are ignored (operand already latched).
//   Latency go-accepted -> Done:
//   - n<=1: 2 cycles (LOAD, DONE).
//   - n>=2: n+1 cycles (LOAD, n-1 MULT cycles, DONE).
//   Arithmetic:
//   - 32x4 unsigned multiply, truncated to 32 bits.
//   - 13! -> 32'd1932053504 with Error=1; 14! -> 32'd1278945280 with Error=1.
// TESTING
//   - rst 2 cycles -> CS=00, Done=0, Error=0, result=0.
//   - in=3, go=1 -> Done pulse after 4 cycles, result=6, Error=0; CS walks 00,01,10,10,11,00.
//   - sweep in=4..12, one run each, go held high between runs -> result=24,120,...,479001600, Error=0.
//   - in=13 then in=14 -> result=1932053504 then 1278945280, Error=1 both.
//   - in=0 and in=1 -> result=1 after 2 cycles, Error=0.
//   - rst asserted during MULT (in=10) -> next cycle CS=00, no Done, result=0.

Source files
------------

// File: rtl/factorial.sv
// Sequential factorial engine: latches a 4-bit operand on go and computes n!
// with one 32x4 multiply per clock, reporting overflow for n > 12.
module factorial (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [3:0]  in,
    output logic        Done,
    output logic        Error,
    output logic [1:0]  CS,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        MULT = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] acc_reg, acc_next;
    logic [31:0] result_reg, result_next;
    logic        error_reg, error_next;
    logic [31:0] product;
    logic [3:0]  cnt_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            acc_reg    <= 32'd0;
            result_reg <= 32'd0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
            error_reg  <= error_next;
        end
    end

    always_comb begin
        product     = acc_reg * {28'd0, cnt_reg};
        cnt_dec     = cnt_reg - 4'd1;
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        result_next = result_reg;
        error_next  = error_reg;

        case (state_reg)
            IDLE: begin
                if (go) begin
                    cnt_next   = in;
                    acc_next   = 32'd1;
                    error_next = (in > 4'd12);
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = (cnt_reg > 4'd1) ? MULT : DONE;
            end
            MULT: begin
                acc_next = product;
                cnt_next = cnt_dec;
                if (cnt_dec <= 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Capture the final product as DONE is entered so result is valid with Done.
        if (state_next == DONE && state_reg != DONE) begin
            result_next = acc_next;
        end
    end

    assign Done   = (state_reg == DONE);
    assign Error  = error_reg;
    assign CS     = state_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_factorial.sv
// Randomized scoreboard bench for the factorial engine: the stimulus side pushes
// expected results computed arithmetically; a negedge monitor checks each Done.
module tb_factorial;

    logic        clk;
    logic        rst;
    logic        go;
    logic [3:0]  in_op;
    logic        done;
    logic        error;
    logic [1:0]  cs;
    logic [31:0] result;

    factorial dut (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .in     (in_op),
        .Done   (done),
        .Error  (error),
        .CS     (cs),
        .result (result)
    );

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          done_edge;
        int          n;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] model_result = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain arithmetic factorial with 32-bit wraparound.
    function automatic logic [31:0] fact_mod32(input int n);
        longint unsigned p = 1;
        for (int i = 2; i <= n; i++) p = (p * longint'(i)) & 64'hFFFF_FFFF;
        return p[31:0];
    endfunction

    // Number of cycles from acceptance to and including the Done cycle.
    function automatic int run_cycles(input int n);
        return (n <= 1) ? 2 : n + 1;
    endfunction

    // Monitor: pops the scoreboard on Done and checks hold behaviour otherwise.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got Done=1 at cycle %0d, expected no Done", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("done_cycle n=%0d", e.n), cyc, e.done_edge);
                check($sformatf("result n=%0d", e.n), result, e.res);
                check($sformatf("error n=%0d", e.n), {31'd0, error}, {31'd0, e.err});
                model_result = e.res;
            end
        end else begin
            if (exp_q.size() != 0 && cyc > exp_q[0].done_edge) begin
                tests++;
                fails++;
                $display("FAIL done_timeout n=%0d: got no Done by cycle %0d, expected at %0d",
                         exp_q[0].n, cyc, exp_q[0].done_edge);
                void'(exp_q.pop_front());
            end
            if (!rst) check("result_hold", result, model_result);
        end
    end

    // One run: entered at a negedge with the engine idle; returns at the negedge
    // after the engine is back in IDLE.
    task automatic run_one(input int n, input logic keep_go);
        exp_t e;
        int   lat;
        int   acc_edge;
        logic [1:0] exp_cs;
        go    = 1'b1;
        in_op = 4'(n);
        @(posedge clk);
        @(negedge clk);
        acc_edge    = cyc;
        lat         = run_cycles(n);
        e.res       = fact_mod32(n);
        e.err       = (n > 12);
        e.done_edge = acc_edge + lat - 1;
        e.n         = n;
        exp_q.push_back(e);
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0)            exp_cs = 2'b01;
            else if (k == lat - 1) exp_cs = 2'b11;
            else if (k == lat)     exp_cs = 2'b00;
            else                   exp_cs = 2'b10;
            check($sformatf("cs n=%0d step=%0d", n, k), {30'd0, cs}, {30'd0, exp_cs});
            if (k < lat) in_op = 4'($urandom_range(0, 15));
            go = keep_go;
        end
        $display("[TB] run n=%0d result=%0d error=%0b", n, result, error);
    endtask

    initial begin
        rst   = 1'b1;
        go    = 1'b0;
        in_op = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_cs", {30'd0, cs}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_one(3, 1'b0);
        for (int n = 4; n <= 12; n++) run_one(n, (n != 12));
        run_one(13, 1'b0);
        run_one(14, 1'b0);
        run_one(0, 1'b0);
        run_one(1, 1'b0);
        run_one(15, 1'b0);

        for (int i = 0; i < 25; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            go = 1'b0;
            for (int g = 0; g < gap; g++) begin
                in_op = 4'($urandom_range(0, 15));
                @(negedge clk);
            end
            run_one($urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end

        // Abort a run in progress with reset; no Done may follow.
        go    = 1'b1;
        in_op = 4'd10;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_in_mult_cs", {30'd0, cs}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs", {30'd0, cs}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_error", {31'd0, error}, 32'd0);
        model_result = 32'd0;
        rst = 1'b0;
        repeat (12) @(negedge clk);

        run_one(5, 1'b0);
        run_one(2, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
